uart_vctr_rx: RTL and testbench
===============================

Name: uart_vctr_rx

Overview:
- Synthesizable UART receiver and packet decoder that loads a bank of NUM_REGS 8-bit vector registers from a serial host link.
- Successor to the fixed 3-register vctr block; generalised in baud rate, register count and header value.
- Adds an optional checksum byte, an inter-byte timeout, and explicit error reporting.
- Sits between the board rx pin and the vector-consuming logic.

Parameters:
- CLK_HZ, 12000000: system clock frequency in Hz.
- BAUD, 9600: line rate. DIV = CLK_HZ/BAUD (integer division); 1250 at the defaults.
- NUM_REGS, 4: number of 8-bit vector registers, range 1..256.
- HEADER, 8'hA5: packet start byte.
- CHK_EN, 0: when 1, every packet carries a trailing XOR checksum byte.
- TIMEOUT_BITS, 20: maximum idle gap between bytes of one packet, counted in bit times.

Ports:
- clock, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rx, input, 1: UART line; idle high; asynchronous to clock.
- vctr, output, NUM_REGS*8: flattened registers; reg i occupies bits [8i+7:8i].
- wr_stb, output, 1: one-cycle pulse when a register is written.
- wr_addr, output, max(1,clog2(NUM_REGS)): index of the last register written.
- rx_data, output, 8: last byte received with a good stop bit.
- rx_valid, output, 1: one-cycle pulse with each new rx_data.
- frame_err, output, 1: one-cycle pulse when a stop bit is sampled low.
- addr_err, output, 1: one-cycle pulse when the address byte is >= NUM_REGS.
- chk_err, output, 1: one-cycle pulse on checksum mismatch.
- timeout_err, output, 1: one-cycle pulse when an inter-byte gap expires mid-packet.

Behaviour:
- Reset, asserted asynchronously, clears:
  - all vctr, wr_addr and rx_data to 0;
  - all pulse outputs to 0;
  - parser to HUNT and byte receiver to IDLE.
  - Reset mid-byte or mid-packet discards the partial data; no write occurs.
- rx passes through a 2-flop synchronizer, initialised to 1 on reset, before any use.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized rx = 0.
  - START: wait DIV/2 clocks, then resample. If rx = 1 the start was a glitch: return to IDLE. Otherwise go to DATA.
  - DATA: sample every DIV clocks, LSB first, 8 bits.
  - STOP: sample after DIV clocks. If 1: update rx_data and pulse rx_valid in the same clock edge. If 0: pulse frame_err, update nothing, and force the parser to HUNT. Either way return to IDLE.
  - Latency: rx_valid rises 1 clock after the mid-stop sample, i.e. about 9.5 bit times plus 2 synchronizer clocks after the start edge.
- Parser states: HUNT, ADDR, DATA, CHK. Transitions act only on rx_valid.
  - HUNT: byte == HEADER -> ADDR; any other byte is ignored.
  - ADDR: latch the address. If address >= NUM_REGS, pulse addr_err and go to HUNT. Otherwise go to DATA.
  - DATA: if CHK_EN = 0, write the byte, then go to HUNT. If CHK_EN = 1, hold the byte and go to CHK.
  - CHK: if the byte equals HEADER^addr^data, write. Otherwise pulse chk_err and do not write. Go to HUNT.
- A write updates vctr[addr] and wr_addr, and pulses wr_stb, all on the clock after rx_valid.
- Registers not addressed hold their values; the last write wins.
- Timeout:
  - The counter is cleared on every rx_valid and runs only while the parser is not in HUNT and the byte receiver is IDLE.
  - Reaching TIMEOUT_BITS*DIV clocks pulses timeout_err and moves the parser to HUNT.
- A header byte arriving in ADDR, DATA or CHK gets no special treatment; it is decoded as that field.
- Simultaneous frame_err and timeout expiry cannot occur, because the timeout counter is idle while a byte is in flight.

Decomposition:
- Shared package uart_pkg holds:
  - parser and byte-receiver state enums;
  - DEFAULT_HEADER = 8'hA5;
  - a clog2 function and the divisor calculation.
- One sub-module, uart_rx_byte, contains the synchronizer, the byte receiver FSM and the baud counter. Its outputs are rx_data, rx_valid and frame_err; its only parameter is DIV.
- The parser, register bank and timeout counter live in uart_vctr_rx.

Test Plan:
- Defaults, send A5 01 AA -> vctr[15:8] = AA, wr_addr = 1, one wr_stb pulse; other registers 0.
- Send A5 00 01, then A5 02 CC, then A5 00 EE -> vctr = {8'h00, 8'hCC, 8'h00, 8'hEE}, three wr_stb pulses.
- NUM_REGS = 4, send A5 05 77 -> addr_err pulse, no wr_stb. A following A5 03 77 -> vctr[31:24] = 77.
- Byte with stop bit 0 during ADDR -> frame_err pulse, parser back to HUNT, no write. The next good packet writes normally.
- CHK_EN = 1:
  - A5 01 AA 0E -> vctr[15:8] = AA.
  - A5 01 AA 0F -> chk_err pulse, register unchanged.
- Send A5 02, idle 25 bit times -> timeout_err pulse; a later 33 alone causes no write.
- Assert rst mid-byte -> all outputs 0; the next full packet is decoded correctly.
- Also run the bench at 9524 baud against the 9600 setting; all packets above must still decode.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encodings and elaboration-time helpers for the UART vector receiver.
package uart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {P_HUNT, P_ADDR, P_DATA, P_CHK} parse_state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: 2-flop synchronizer, mid-bit sampling, 8N1 framing.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int DIV = 1250
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [1:0] state
);

  localparam int CW = clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);

  rx_state_e     state_q, state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      // Half a bit in: a line that is high again was only a glitch.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign state     = state_q;

endmodule

// File: rtl/uart_vctr_rx.sv
// Serial packet decoder (HEADER, addr, data[, xor checksum]) loading a bank of 8-bit registers.
module uart_vctr_rx
  import uart_pkg::*;
#(
  parameter int          CLK_HZ       = 12000000,
  parameter int          BAUD         = 9600,
  parameter int          NUM_REGS     = 4,
  parameter logic [7:0]  HEADER       = DEFAULT_HEADER,
  parameter bit          CHK_EN       = 1'b0,
  parameter int          TIMEOUT_BITS = 20,
  localparam int         AW           = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rx,
  output logic [NUM_REGS*8-1:0] vctr,
  output logic                  wr_stb,
  output logic [AW-1:0]         wr_addr,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  addr_err,
  output logic                  chk_err,
  output logic                  timeout_err
);

  localparam int DIV      = calc_div(CLK_HZ, BAUD);
  localparam int TO_LIMIT = TIMEOUT_BITS * DIV;
  localparam int TW       = clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);
  localparam logic [8:0]    NREGS9  = 9'(NUM_REGS);

  logic [7:0] byte_data;
  logic       byte_valid, byte_ferr;
  logic [1:0] rx_state;

  uart_rx_byte #(.DIV(DIV)) u_rx_byte (
    .clock     (clock),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (byte_data),
    .rx_valid  (byte_valid),
    .frame_err (byte_ferr),
    .state     (rx_state)
  );

  parse_state_e          ps_q, ps_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [NUM_REGS*8-1:0] vctr_q, vctr_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic                  wr_stb_q, wr_stb_d;
  logic                  addr_err_q, addr_err_d;
  logic                  chk_err_q, chk_err_d;
  logic                  to_err_q, to_err_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  do_write;
  logic [7:0]            wbyte;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ps_q       <= P_HUNT;
      addr_q     <= '0;
      data_q     <= '0;
      vctr_q     <= '0;
      wr_addr_q  <= '0;
      wr_stb_q   <= 1'b0;
      addr_err_q <= 1'b0;
      chk_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      ps_q       <= ps_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      vctr_q     <= vctr_d;
      wr_addr_q  <= wr_addr_d;
      wr_stb_q   <= wr_stb_d;
      addr_err_q <= addr_err_d;
      chk_err_q  <= chk_err_d;
      to_err_q   <= to_err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    ps_d       = ps_q;
    addr_d     = addr_q;
    data_d     = data_q;
    vctr_d     = vctr_q;
    wr_addr_d  = wr_addr_q;
    wr_stb_d   = 1'b0;
    addr_err_d = 1'b0;
    chk_err_d  = 1'b0;
    to_err_d   = 1'b0;
    to_cnt_d   = to_cnt_q;
    do_write   = 1'b0;
    wbyte      = byte_data;
    if (byte_ferr) begin
      ps_d     = P_HUNT;
      to_cnt_d = '0;
    end else if (byte_valid) begin
      to_cnt_d = '0;
      case (ps_q)
        P_HUNT: if (byte_data == HEADER) ps_d = P_ADDR;
        P_ADDR: begin
          addr_d = byte_data;
          if ({1'b0, byte_data} >= NREGS9) begin
            addr_err_d = 1'b1;
            ps_d       = P_HUNT;
          end else begin
            ps_d = P_DATA;
          end
        end
        P_DATA: begin
          if (CHK_EN) begin
            data_d = byte_data;
            ps_d   = P_CHK;
          end else begin
            do_write = 1'b1;
            ps_d     = P_HUNT;
          end
        end
        P_CHK: begin
          ps_d = P_HUNT;
          if (byte_data == (HEADER ^ addr_q ^ data_q)) begin
            do_write = 1'b1;
            wbyte    = data_q;
          end else begin
            chk_err_d = 1'b1;
          end
        end
        default: ps_d = P_HUNT;
      endcase
    end else if (ps_q == P_HUNT) begin
      to_cnt_d = '0;
    end else if (rx_state == RX_IDLE) begin
      // Gap timer only advances between bytes; it holds while a byte is in flight.
      if (to_cnt_q == TO_LAST) begin
        to_err_d = 1'b1;
        ps_d     = P_HUNT;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (do_write) begin
      wr_stb_d  = 1'b1;
      wr_addr_d = addr_q[AW-1:0];
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_q == 8'(i)) vctr_d[i*8 +: 8] = wbyte;
      end
    end
  end

  assign vctr        = vctr_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign rx_data     = byte_data;
  assign rx_valid    = byte_valid;
  assign frame_err   = byte_ferr;
  assign addr_err    = addr_err_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_uart_vctr_rx.sv
`timescale 1ns/1ps
// Bench for uart_vctr_rx: instance a without checksum, instance c with checksum,
// shared clock and reset, separate serial lines driven from a packet-level model.
module tb_uart_vctr_rx;

  localparam int         CLK_HZ   = 153600;
  localparam int         BAUD     = 9600;
  localparam int         NUM_REGS = 4;
  localparam int         TO_BITS  = 20;
  localparam logic [7:0] HDR      = 8'hA5;
  localparam real        BIT_NOM  = 10.0 * CLK_HZ / BAUD;
  localparam real        BIT_SLOW = 10.0 * CLK_HZ / 9524.0;

  logic clock, rst, rx_a, rx_c;
  logic [NUM_REGS*8-1:0] vctr_a, vctr_c;
  logic [1:0] wr_addr_a, wr_addr_c;
  logic [7:0] rx_data_a, rx_data_c;
  logic wr_stb_a, wr_stb_c, rx_valid_a, rx_valid_c, frame_err_a, frame_err_c;
  logic addr_err_a, addr_err_c, chk_err_a, chk_err_c, timeout_err_a, timeout_err_c;

  uart_vctr_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_REGS(NUM_REGS), .HEADER(HDR),
                 .CHK_EN(1'b0), .TIMEOUT_BITS(TO_BITS)) dut_a (
    .clock(clock), .rst(rst), .rx(rx_a), .vctr(vctr_a), .wr_stb(wr_stb_a),
    .wr_addr(wr_addr_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .frame_err(frame_err_a), .addr_err(addr_err_a), .chk_err(chk_err_a),
    .timeout_err(timeout_err_a));

  uart_vctr_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_REGS(NUM_REGS), .HEADER(HDR),
                 .CHK_EN(1'b1), .TIMEOUT_BITS(TO_BITS)) dut_c (
    .clock(clock), .rst(rst), .rx(rx_c), .vctr(vctr_c), .wr_stb(wr_stb_c),
    .wr_addr(wr_addr_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c),
    .frame_err(frame_err_c), .addr_err(addr_err_c), .chk_err(chk_err_c),
    .timeout_err(timeout_err_c));

  int  checks = 0;
  int  failures = 0;
  real bit_ns = BIT_NOM;

  logic [7:0] mdl [2][NUM_REGS];
  logic [1:0] mdl_waddr [2];
  logic [7:0] mdl_rxd [2];
  int e_wr[2] = '{0, 0}, e_aerr[2] = '{0, 0}, e_cerr[2] = '{0, 0}, e_ferr[2] = '{0, 0}, e_to[2] = '{0, 0};
  int n_wr[2] = '{0, 0}, n_aerr[2] = '{0, 0}, n_cerr[2] = '{0, 0}, n_ferr[2] = '{0, 0}, n_to[2] = '{0, 0};
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // pulse monitors: count high cycles so a stretched pulse shows up as extra counts
  always @(negedge clock) begin
    if (wr_stb_a) n_wr[0]++;
    if (wr_stb_c) n_wr[1]++;
    if (addr_err_a) n_aerr[0]++;
    if (addr_err_c) n_aerr[1]++;
    if (chk_err_a) n_cerr[0]++;
    if (chk_err_c) n_cerr[1]++;
    if (frame_err_a) n_ferr[0]++;
    if (frame_err_c) n_ferr[1]++;
    if (timeout_err_a) n_to[0]++;
    if (timeout_err_c) n_to[1]++;
    if (rx_valid_a) got_q.push_back(rx_data_a);
  end

  function automatic logic [NUM_REGS*8-1:0] exp_flat(input int inst);
    logic [NUM_REGS*8-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = mdl[inst][i];
    return f;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_REGS; i++) mdl[k][i] = 8'h00;
      mdl_waddr[k] = 2'd0;
      mdl_rxd[k] = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_a = 1'b1;
    rx_c = 1'b1;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    clear_model();
  endtask

  // driver tasks
  task automatic drive_line(input int inst, input logic v);
    if (inst == 0) rx_a = v;
    else rx_c = v;
  endtask

  task automatic send_byte(input int inst, input logic [7:0] b, input logic stop_ok);
    drive_line(inst, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      drive_line(inst, b[i]);
      #(bit_ns);
    end
    if (stop_ok) begin
      drive_line(inst, 1'b1);
      #(bit_ns * 2.0);
      mdl_rxd[inst] = b;
      if (inst == 0) exp_q.push_back(b);
    end else begin
      drive_line(inst, 1'b0);
      #(bit_ns * 0.75);
      drive_line(inst, 1'b1);
      #(bit_ns * 1.25);
      e_ferr[inst]++;
    end
  endtask

  task automatic send_pkt(input int inst, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] chk);
    send_byte(inst, HDR, 1'b1);
    send_byte(inst, addr, 1'b1);
    if (addr >= NUM_REGS) begin
      e_aerr[inst]++;
      if (inst == 0) send_byte(inst, data, 1'b1);
    end else begin
      send_byte(inst, data, 1'b1);
      if (inst == 1) send_byte(inst, chk, 1'b1);
      if (inst == 0 || chk == (HDR ^ addr ^ data)) begin
        mdl[inst][addr[1:0]] = data;
        mdl_waddr[inst] = addr[1:0];
        e_wr[inst]++;
      end else begin
        e_cerr[inst]++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #(bit_ns);
    checks++;
    if (vctr_a !== '0 || vctr_c !== '0) begin
      failures++;
      $display("FAIL reset_vctr: got %h/%h expected 0", vctr_a, vctr_c);
    end
    checks++;
    if (wr_addr_a !== 2'd0 || wr_addr_c !== 2'd0) begin
      failures++;
      $display("FAIL reset_wr_addr: got %0d/%0d expected 0", wr_addr_a, wr_addr_c);
    end
    checks++;
    if (rx_data_a !== 8'h00 || rx_data_c !== 8'h00) begin
      failures++;
      $display("FAIL reset_rx_data: got %h/%h expected 0", rx_data_a, rx_data_c);
    end
    checks++;
    if ({wr_stb_a, rx_valid_a, frame_err_a, addr_err_a, chk_err_a, timeout_err_a,
         wr_stb_c, rx_valid_c, frame_err_c, addr_err_c, chk_err_c, timeout_err_c} !== 12'd0) begin
      failures++;
      $display("FAIL reset_pulses: a pulse output is not 0 after reset");
    end
  endtask

  task automatic test_basic_write();
    int s_wr;
    s_wr = n_wr[0];
    send_pkt(0, 8'h01, 8'hAA, 8'h00);
    #(bit_ns);
    checks++;
    if (vctr_a !== 32'h0000AA00) begin
      failures++;
      $display("FAIL basic_vctr: got %h expected %h", vctr_a, 32'h0000AA00);
    end
    checks++;
    if (wr_addr_a !== 2'd1) begin
      failures++;
      $display("FAIL basic_wr_addr: got %0d expected 1", wr_addr_a);
    end
    checks++;
    if (n_wr[0] - s_wr !== 1) begin
      failures++;
      $display("FAIL basic_wr_stb: got %0d pulse cycles expected 1", n_wr[0] - s_wr);
    end
    checks++;
    if (rx_data_a !== 8'hAA) begin
      failures++;
      $display("FAIL basic_rx_data: got %h expected aa", rx_data_a);
    end
  endtask

  task automatic test_multi_write();
    int s_wr;
    do_reset();
    s_wr = n_wr[0];
    send_pkt(0, 8'h00, 8'h01, 8'h00);
    send_pkt(0, 8'h02, 8'hCC, 8'h00);
    send_pkt(0, 8'h00, 8'hEE, 8'h00);
    #(bit_ns);
    checks++;
    if (vctr_a !== 32'h00CC00EE) begin
      failures++;
      $display("FAIL multi_vctr: got %h expected 00cc00ee", vctr_a);
    end
    checks++;
    if (n_wr[0] - s_wr !== 3) begin
      failures++;
      $display("FAIL multi_wr_stb: got %0d expected 3", n_wr[0] - s_wr);
    end
    checks++;
    if (wr_addr_a !== mdl_waddr[0]) begin
      failures++;
      $display("FAIL multi_wr_addr: got %0d expected %0d", wr_addr_a, mdl_waddr[0]);
    end
  endtask

  task automatic test_addr_err();
    int s_wr, s_ae;
    s_wr = n_wr[0];
    s_ae = n_aerr[0];
    send_pkt(0, 8'h05, 8'h77, 8'h00);
    #(bit_ns);
    checks++;
    if (n_aerr[0] - s_ae !== 1 || n_wr[0] !== s_wr) begin
      failures++;
      $display("FAIL addr_err_pulse: got aerr=%0d wr=%0d expected aerr=1 wr=0",
               n_aerr[0] - s_ae, n_wr[0] - s_wr);
    end
    send_pkt(0, 8'h03, 8'h77, 8'h00);
    #(bit_ns);
    checks++;
    if (vctr_a[31:24] !== 8'h77) begin
      failures++;
      $display("FAIL addr_err_recover: got %h expected 77", vctr_a[31:24]);
    end
    checks++;
    if (vctr_a !== exp_flat(0)) begin
      failures++;
      $display("FAIL addr_err_vctr: got %h expected %h", vctr_a, exp_flat(0));
    end
  endtask

  task automatic test_frame_err();
    int s_wr, s_fe;
    s_wr = n_wr[0];
    s_fe = n_ferr[0];
    send_byte(0, HDR, 1'b1);
    send_byte(0, 8'h02, 1'b0);
    // A parser left in ADDR would take these as address 1 and data 33.
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h33, 1'b1);
    #(bit_ns);
    checks++;
    if (n_ferr[0] - s_fe !== 1) begin
      failures++;
      $display("FAIL frame_err_pulse: got %0d expected 1", n_ferr[0] - s_fe);
    end
    checks++;
    if (n_wr[0] !== s_wr || vctr_a !== exp_flat(0)) begin
      failures++;
      $display("FAIL frame_err_nowrite: got vctr %h wr %0d expected %h wr 0",
               vctr_a, n_wr[0] - s_wr, exp_flat(0));
    end
    send_pkt(0, 8'h02, 8'h5A, 8'h00);
    #(bit_ns);
    checks++;
    if (vctr_a !== exp_flat(0)) begin
      failures++;
      $display("FAIL frame_err_recover: got %h expected %h", vctr_a, exp_flat(0));
    end
    checks++;
    if (rx_data_a !== mdl_rxd[0]) begin
      failures++;
      $display("FAIL frame_err_rx_data: got %h expected %h", rx_data_a, mdl_rxd[0]);
    end
  endtask

  task automatic test_timeout();
    int s_wr, s_to;
    s_to = n_to[0];
    s_wr = n_wr[0];
    send_byte(0, HDR, 1'b1);
    send_byte(0, 8'h02, 1'b1);
    #(bit_ns * 25.0);
    e_to[0]++;
    checks++;
    if (n_to[0] - s_to !== 1) begin
      failures++;
      $display("FAIL timeout_pulse: got %0d expected 1", n_to[0] - s_to);
    end
    send_byte(0, 8'h33, 1'b1);
    #(bit_ns);
    checks++;
    if (n_wr[0] !== s_wr || vctr_a !== exp_flat(0)) begin
      failures++;
      $display("FAIL timeout_nowrite: got vctr %h expected %h", vctr_a, exp_flat(0));
    end
    // A 15-bit gap stays inside the limit.
    send_byte(0, HDR, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    #(bit_ns * 15.0);
    send_byte(0, 8'h55, 1'b1);
    mdl[0][1] = 8'h55;
    mdl_waddr[0] = 2'd1;
    e_wr[0]++;
    #(bit_ns);
    checks++;
    if (n_to[0] - s_to !== 1) begin
      failures++;
      $display("FAIL timeout_short_gap: got %0d expected 1", n_to[0] - s_to);
    end
    checks++;
    if (vctr_a !== exp_flat(0)) begin
      failures++;
      $display("FAIL timeout_short_vctr: got %h expected %h", vctr_a, exp_flat(0));
    end
  endtask

  task automatic test_checksum();
    int s_ce;
    s_ce = n_cerr[1];
    send_pkt(1, 8'h01, 8'hAA, 8'h0E);
    #(bit_ns);
    checks++;
    if (vctr_c[15:8] !== 8'hAA) begin
      failures++;
      $display("FAIL chk_good: got %h expected aa", vctr_c[15:8]);
    end
    send_pkt(1, 8'h01, 8'hAA, 8'h0F);
    send_pkt(1, 8'h01, 8'h11, 8'h00);
    #(bit_ns);
    checks++;
    if (n_cerr[1] - s_ce !== 2) begin
      failures++;
      $display("FAIL chk_err_pulse: got %0d expected 2", n_cerr[1] - s_ce);
    end
    checks++;
    if (vctr_c !== 32'h0000AA00) begin
      failures++;
      $display("FAIL chk_bad_nowrite: got %h expected 0000aa00", vctr_c);
    end
  endtask

  task automatic test_random(input int npkt);
    fork
      begin
        for (int p = 0; p < npkt; p++) begin
          logic [7:0] a, d;
          a = 8'($urandom_range(0, 5));
          d = 8'($urandom_range(0, 255));
          if (a >= NUM_REGS && d == HDR) d = 8'h5A;
          send_pkt(0, a, d, 8'h00);
        end
      end
      begin
        for (int p = 0; p < npkt; p++) begin
          logic [7:0] a, d, c;
          a = 8'($urandom_range(0, NUM_REGS - 1));
          d = 8'($urandom_range(0, 255));
          c = HDR ^ a ^ d;
          if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
          send_pkt(1, a, d, c);
        end
      end
    join
    #(bit_ns);
    checks++;
    if (vctr_a !== exp_flat(0)) begin
      failures++;
      $display("FAIL random_vctr_a: got %h expected %h", vctr_a, exp_flat(0));
    end
    checks++;
    if (vctr_c !== exp_flat(1)) begin
      failures++;
      $display("FAIL random_vctr_c: got %h expected %h", vctr_c, exp_flat(1));
    end
  endtask

  task automatic test_reset_mid_byte();
    int s_wr;
    send_pkt(0, 8'h01, 8'h42, 8'h00);
    send_byte(0, HDR, 1'b1);
    rx_a = 1'b0;
    #(bit_ns);
    rx_a = 1'b1;
    #(bit_ns);
    rx_a = 1'b0;
    #(bit_ns * 2.0);
    do_reset();
    #(bit_ns);
    checks++;
    if (vctr_a !== '0 || vctr_c !== '0) begin
      failures++;
      $display("FAIL midreset_vctr: got %h/%h expected 0", vctr_a, vctr_c);
    end
    checks++;
    if (wr_addr_a !== 2'd0 || rx_data_a !== 8'h00) begin
      failures++;
      $display("FAIL midreset_regs: got wr_addr %0d rx_data %h expected 0", wr_addr_a, rx_data_a);
    end
    s_wr = n_wr[0];
    send_pkt(0, 8'h02, 8'h3C, 8'h00);
    #(bit_ns);
    checks++;
    if (vctr_a !== 32'h003C0000 || wr_addr_a !== 2'd2) begin
      failures++;
      $display("FAIL midreset_recover: got %h addr %0d expected 003c0000 addr 2", vctr_a, wr_addr_a);
    end
    checks++;
    if (n_wr[0] - s_wr !== 1) begin
      failures++;
      $display("FAIL midreset_wr_stb: got %0d expected 1", n_wr[0] - s_wr);
    end
  endtask

  task automatic test_slow_baud();
    do_reset();
    bit_ns = BIT_SLOW;
    send_pkt(0, 8'h00, 8'h01, 8'h00);
    send_pkt(0, 8'h02, 8'hCC, 8'h00);
    send_pkt(0, 8'h00, 8'hEE, 8'h00);
    send_pkt(0, 8'h05, 8'h77, 8'h00);
    send_pkt(0, 8'h03, 8'h77, 8'h00);
    send_pkt(1, 8'h01, 8'hAA, 8'h0E);
    #(bit_ns);
    checks++;
    if (vctr_a !== 32'h77CC00EE) begin
      failures++;
      $display("FAIL slow_vctr_a: got %h expected 77cc00ee", vctr_a);
    end
    checks++;
    if (vctr_c !== 32'h0000AA00) begin
      failures++;
      $display("FAIL slow_vctr_c: got %h expected 0000aa00", vctr_c);
    end
    test_random(5);
    bit_ns = BIT_NOM;
  endtask

  // scoreboard: every good-stop byte on line a must appear once, in order, on rx_data
  task automatic test_scoreboard();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL sb_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL sb_byte: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_totals();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (n_wr[k] !== e_wr[k]) begin
        failures++;
        $display("FAIL total_wr[%0d]: got %0d expected %0d", k, n_wr[k], e_wr[k]);
      end
      checks++;
      if (n_aerr[k] !== e_aerr[k]) begin
        failures++;
        $display("FAIL total_addr_err[%0d]: got %0d expected %0d", k, n_aerr[k], e_aerr[k]);
      end
      checks++;
      if (n_cerr[k] !== e_cerr[k]) begin
        failures++;
        $display("FAIL total_chk_err[%0d]: got %0d expected %0d", k, n_cerr[k], e_cerr[k]);
      end
      checks++;
      if (n_ferr[k] !== e_ferr[k]) begin
        failures++;
        $display("FAIL total_frame_err[%0d]: got %0d expected %0d", k, n_ferr[k], e_ferr[k]);
      end
      checks++;
      if (n_to[k] !== e_to[k]) begin
        failures++;
        $display("FAIL total_timeout[%0d]: got %0d expected %0d", k, n_to[k], e_to[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_multi_write();
    test_addr_err();
    test_frame_err();
    test_timeout();
    test_checksum();
    test_random(10);
    test_reset_mid_byte();
    test_slow_baud();
    test_scoreboard();
    test_totals();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
